// File: rtl/alu_seq.sv
// Registered, handshaked ALU with carry/zero/err flags.
// Iterative multiply/divide is built only when ALU_SEQ_MULDIV_EN is defined.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic             err,
  output logic [1:0]       dbg_state
);

  localparam int SHW = $clog2(WIDTH);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; the producer holds its payload until that edge.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic go_busy;
  logic last;
  logic accept;

  logic [SHW-1:0]   amt;
  logic [SHW:0]     ramt;
  logic [WIDTH:0]   add_w;
  logic [WIDTH-1:0] sc_out;
  logic             sc_carry;
  logic             sc_err;

  assign accept = (state == S_IDLE) && in_valid;

  // Single-cycle datapath, evaluated on the operands present at the accept edge.
  always_comb begin
    amt      = B[SHW-1:0];
    ramt     = (SHW+1)'(WIDTH) - {1'b0, amt};
    add_w    = {1'b0, A} + {1'b0, B};
    sc_out   = '0;
    sc_carry = 1'b0;
    sc_err   = 1'b0;
    case (sel)
      4'b0000: begin
        sc_out   = add_w[WIDTH-1:0];
        sc_carry = add_w[WIDTH];
      end
      4'b0001: begin
        sc_out   = A - B;
        sc_carry = (A < B);
      end
      4'b0100: sc_out = A << amt;
      4'b0101: sc_out = A >> amt;
      // A shift by a full WIDTH yields 0, so amount 0 degenerates to A.
      4'b0110: sc_out = (A << amt) | (A >> ramt);
      4'b0111: sc_out = (A >> amt) | (A << ramt);
      4'b1000: sc_out = A & B;
      4'b1001: sc_out = A | B;
      4'b1010: sc_out = A ^ B;
      4'b1011: sc_out = ~(A | B);
      4'b1100: sc_out = ~(A & B);
      4'b1101: sc_out = ~(A ^ B);
      4'b1110: sc_out = {{(WIDTH-1){1'b0}}, (A > B)};
      4'b1111: sc_out = {{(WIDTH-1){1'b0}}, (A == B)};
      default: sc_err = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MULDIV_EN
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opnd;
  logic             is_div;
  logic [SHW:0]     cnt;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_r;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;

  assign go_busy = (sel[3:1] == 3'b001);
  assign last    = (state == S_BUSY) && (cnt == (SHW+1)'(1));

  // hi:lo is the product (mul) or remainder:quotient (div); opnd is the
  // multiplicand or divisor. One bit is retired per BUSY cycle.
  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    div_r    = {hi, lo[WIDTH-1]};
    div_diff = div_r - {1'b0, opnd};
    if (is_div) begin
      if (div_diff[WIDTH]) begin
        hi_nxt = div_r[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b0};
      end else begin
        hi_nxt = div_diff[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b1};
      end
    end else begin
      hi_nxt = mul_sum[WIDTH:1];
      lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      cnt    <= '0;
    end else if (accept && go_busy) begin
      hi     <= '0;
      lo     <= sel[0] ? A : B;
      opnd   <= sel[0] ? B : A;
      is_div <= sel[0];
      cnt    <= (SHW+1)'(WIDTH);
    end else if (state == S_BUSY) begin
      hi  <= hi_nxt;
      lo  <= lo_nxt;
      cnt <= cnt - (SHW+1)'(1);
    end
  end
`else
  assign go_busy = 1'b0;
  assign last    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = go_busy ? S_BUSY : S_DONE;
      S_BUSY:  if (last) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic; in_ready drops as soon as reset is asserted.
  always_comb begin
    in_ready  = rst_n && (state == S_IDLE);
    out_valid = (state == S_DONE);
    dbg_state = state;
  end

  // Result register only loads on accept or on the final iteration, so it
  // stays frozen for the whole DONE phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out   <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
      err   <= 1'b0;
    end else if (accept && !go_busy) begin
      out   <= sc_out;
      carry <= sc_carry;
      zero  <= (sc_out == '0);
      err   <= sc_err;
    end
`ifdef ALU_SEQ_MULDIV_EN
    else if (last) begin
      out   <= lo_nxt;
      carry <= is_div ? 1'b0 : (|hi_nxt);
      zero  <= (lo_nxt == '0);
      err   <= is_div && (opnd == '0);
    end
`endif
  end

endmodule
